// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared constants for the binary-to-BCD display path: FSM encodings and the
// saturated display code.
package bin_to_bcd_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] BCD_SAT_VALUE = 8'h99;

endpackage

// File: rtl/bin_to_bcd_serial_add3.sv
// One BCD digit correction cell for double-dabble: digits of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter, one shift per clock, with registered results
// that hold between conversions and feed the two-digit seven-segment decoder.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; results hold the last conversion
// ST_SHIFT | add-3 correction then one left shift of {acc,sh} per edge
// ST_DONE  | final digits in acc; next edge publishes them and pulses done
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int IW  = 8,
  parameter int ND  = 3,
  parameter int SAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IW-1:0]   bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd,
  output logic [7:0]      disp_byte,
  output logic            overflow
);

  localparam int CW = $clog2(IW + 1);

  logic [1:0]      state;
  logic [4*ND-1:0] acc;
  logic [4*ND-1:0] acc_adj;
  logic [IW-1:0]   sh;
  logic [CW-1:0]   cnt;
  logic            ovf_next;

  for (genvar g = 0; g < ND; g++) begin : g_digit
    bcd_add3_digit u_digit (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Anything in the hundreds digit or above cannot be shown on two digits.
  assign ovf_next = |acc[4*ND-1:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      sh        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      disp_byte <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh    <= bin;
            acc   <= '0;
            cnt   <= CW'(IW);
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {acc, sh} <= {acc_adj[4*ND-2:0], sh, 1'b0};
          cnt       <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd       <= acc;
          overflow  <= ovf_next;
          disp_byte <= ((SAT != 0) && ovf_next) ? BCD_SAT_VALUE : acc[7:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed bench for bin_to_bcd_serial: a saturating and a wrapping instance
// share stimulus; table vectors plus hand-written handshake/reset sequences.
module tb_bin_to_bcd_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin;

  logic        busy_s, done_s, ovf_s;
  logic [11:0] bcd_s;
  logic [7:0]  disp_s;
  logic        busy_w, done_w, ovf_w;
  logic [11:0] bcd_w;
  logic [7:0]  disp_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_serial #(.IW(8), .ND(3), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy_s), .done(done_s), .bcd(bcd_s), .disp_byte(disp_s), .overflow(ovf_s)
  );

  bin_to_bcd_serial #(.IW(8), .ND(3), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy_w), .done(done_w), .bcd(bcd_w), .disp_byte(disp_w), .overflow(ovf_w)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [7:0]  disp_sat;
    logic [7:0]  disp_wrap;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one start (inputs changed 1ns after an edge), then wait for done.
  task automatic convert(input logic [7:0] b, output int lat, output int busy_cnt);
    start = 1'b1;
    bin   = b;
    @(posedge clk); #1;
    start    = 1'b0;
    bin      = 8'($urandom);
    busy_cnt = busy_s ? 1 : 0;
    lat      = 0;
    while (!done_s && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy_s) busy_cnt++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [11:0] held;

    vecs[0] = '{8'd0,   12'h000, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'd42,  12'h042, 8'h42, 8'h42, 1'b0};
    vecs[2] = '{8'd99,  12'h099, 8'h99, 8'h99, 1'b0};
    vecs[3] = '{8'd100, 12'h100, 8'h99, 8'h00, 1'b1};
    vecs[4] = '{8'd255, 12'h255, 8'h99, 8'h55, 1'b1};
    vecs[5] = '{8'd9,   12'h009, 8'h09, 8'h09, 1'b0};
    vecs[6] = '{8'd10,  12'h010, 8'h10, 8'h10, 1'b0};
    vecs[7] = '{8'd128, 12'h128, 8'h99, 8'h28, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_s), 32'd0);
    check("reset_done", 32'(done_s), 32'd0);
    check("reset_bcd",  32'(bcd_s),  32'h000);
    check("reset_disp", 32'(disp_s), 32'h00);
    check("reset_ovf",  32'(ovf_s),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, lat, bcnt);
      check($sformatf("latency[%0d]", vecs[i].bin), 32'(lat), 32'd9);
      check($sformatf("busy_cycles[%0d]", vecs[i].bin), 32'(bcnt), 32'd9);
      check($sformatf("bcd[%0d]", vecs[i].bin), 32'(bcd_s), 32'(vecs[i].bcd));
      check($sformatf("bcd_wrap[%0d]", vecs[i].bin), 32'(bcd_w), 32'(vecs[i].bcd));
      check($sformatf("disp_sat[%0d]", vecs[i].bin), 32'(disp_s), 32'(vecs[i].disp_sat));
      check($sformatf("disp_wrap[%0d]", vecs[i].bin), 32'(disp_w), 32'(vecs[i].disp_wrap));
      check($sformatf("ovf[%0d]", vecs[i].bin), 32'(ovf_s), 32'(vecs[i].ovf));
      check($sformatf("ovf_wrap[%0d]", vecs[i].bin), 32'(ovf_w), 32'(vecs[i].ovf));
      check($sformatf("done_wrap[%0d]", vecs[i].bin), 32'(done_w), 32'd1);
      @(posedge clk); #1;
      check($sformatf("done_width[%0d]", vecs[i].bin), 32'(done_s), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("hold_bcd[%0d]", vecs[i].bin), 32'(bcd_s), 32'(vecs[i].bcd));
    end

    // Start while busy is ignored; only one done pulse follows.
    start = 1'b1; bin = 8'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_s) dcnt++;
    end
    check("busy_start_done_count", 32'(dcnt), 32'd1);
    check("busy_start_bcd", 32'(bcd_s), 32'h017);

    // Back-to-back: next start sampled on the edge right after done rises.
    convert(8'd55, lat, bcnt);
    check("b2b_first_bcd", 32'(bcd_s), 32'h055);
    convert(8'd77, lat, bcnt);
    check("b2b_second_latency", 32'(lat), 32'd9);
    check("b2b_second_bcd", 32'(bcd_s), 32'h077);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between edges in the middle of SHIFT.
    start = 1'b1; bin = 8'd63;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    held = bcd_s;
    check("pre_reset_bcd", 32'(held), 32'h077);
    reset = 1'b1;
    #1;
    check("async_reset_bcd",  32'(bcd_s),  32'h000);
    check("async_reset_disp", 32'(disp_s), 32'h00);
    check("async_reset_busy", 32'(busy_s), 32'd0);
    check("async_reset_ovf",  32'(ovf_s),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_s) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    check("abort_busy", 32'(busy_s), 32'd0);
    convert(8'd63, lat, bcnt);
    check("post_reset_latency", 32'(lat), 32'd9);
    check("post_reset_bcd", 32'(bcd_s), 32'h063);
    check("post_reset_disp", 32'(disp_s), 32'h63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential double-dabble converter: turns an 8-bit binary value into BCD digits, one shift per clock.
- Sits directly upstream of the two-digit seven-segment decoder. Its packed {tens,ones} byte drives the decoder's 8-bit address input, so the display shows decimal instead of hex.
- Start/busy/done handshake; results are held stable between conversions.
- Values above 99 raise an overflow flag and, optionally, saturate the display byte.

Parameters:
- IW, 8, binary input width in bits.
- ND, 3, number of BCD digits produced; must satisfy 10^ND > 2^IW - 1.
- SAT, 1, 1 means disp_byte saturates to 8'h99 on overflow; 0 means it shows the low two digits (wrap).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to convert bin; sampled only in IDLE.
- bin  input  IW  binary value; latched on the accepted start.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse when the results update.
- bcd  output  4*ND  all digits; digit 0 (ones) is in [3:0].
- disp_byte  output  8  {tens,ones}, or 8'h99 if SAT and overflow; feeds the decoder addr.
- overflow  output  1  high when the converted value exceeds 99.

Behaviour:
- Reset (async, active-high), applied immediately:
  - state=IDLE; busy=0, done=0, bcd=0, disp_byte=8'h00, overflow=0.
  - Internal shift register and counter cleared.
  - Reset mid-conversion aborts it; no done pulse follows.
- Registers:
  - shift register {acc[4*ND-1:0], sh[IW-1:0]}.
  - counter cnt, width $clog2(IW+1).
- IDLE:
  - busy=0.
  - On start=1 at an edge: sh<=bin, acc<=0, cnt<=IW, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per edge:
  - Every acc digit >=5 gets +3 (4-bit add, no carry between digits).
  - Then {acc,sh} shifts left by 1; cnt decrements.
  - When cnt reaches 1 at an edge, that edge performs the final shift and moves to DONE.
  - Exactly IW shift edges occur.
- DONE, exactly one cycle:
  - On entry edge: bcd<=acc, overflow<=(acc[4*ND-1:8]!=0), disp_byte computed from the new acc, done<=1.
  - Next edge: done<=0, go to IDLE.
- Latency: start sampled at edge E0 → shifts on E1..E(IW) → outputs and done valid after edge E(IW+1), i.e. 9 cycles for IW=8. busy high after E0 through E(IW+1). Back-to-back: earliest next accepted start is at edge E(IW+2).
- start while busy (SHIFT or DONE) is ignored; no queueing.
- bin may change freely after the accepted start edge.
- Between conversions, bcd/disp_byte/overflow hold their last values; they never show intermediate shift states.
- All outputs are registered; no combinational path from start or bin to any output.
- Boundary values:
  - bin=0 → all zero.
  - bin=2^IW-1 (255) → hundreds=2, tens=5, ones=5.
  - Exactly 99 → no overflow.
  - 100 → overflow.

Decomposition:
- Shared package/header (alongside the existing clock-divider constants):
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - BCD_SAT_VALUE=8'h99.
- One natural sub-module: bcd_add3_digit, the combinational 4-bit "if >=5 add 3" cell, instantiated ND times via generate.
- Everything else (FSM, counter, output registers) lives in bin_to_bcd_serial.

Test Plan:
1. Reset, then start with bin=8'd0 → done pulses 9 cycles after start; bcd=12'h000, disp_byte=8'h00, overflow=0.
2. bin=8'd42 → bcd=12'h042, disp_byte=8'h42, overflow=0. busy is high for exactly 9 cycles; done is high for exactly 1 cycle.
3. bin=8'd99, then bin=8'd100 (SAT=1) → first: disp_byte=8'h99, overflow=0. Second: bcd=12'h100, disp_byte=8'h99, overflow=1.
4. bin=8'd255 with SAT=0 → bcd=12'h255, disp_byte=8'h55, overflow=1.
5. Start bin=8'd17, then pulse start with bin=8'd200 three cycles later → second start ignored; result bcd=12'h017; exactly one done pulse.
6. Start bin=8'd63, assert reset asynchronously mid-SHIFT (between edges) → outputs zero immediately, no done pulse. After release, a new start with bin=8'd63 gives bcd=12'h063.
